// File: rtl/mem_stage.sv
// rv32 memory-access stage: issues one req/ack data-memory transaction per load/store,
// aligns/extends load data and drives the M/WB register; stalls upstream while busy.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_aluresult,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_load,
  input  logic            ex_mem_store,
  input  logic            ex_reg_wr,
  input  logic [4:0]      ex_reg_wnum,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misalign,
  output logic            wb_valid,
  output logic            wb_reg_wr,
  output logic            wb_mem_load,
  output logic [4:0]      wb_reg_wnum,
  output logic [XLEN-1:0] wb_aluresult,
  output logic [XLEN-1:0] wb_mem_dat_i_w,
  output logic [XLEN-1:0] wb_data_out
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            rw_q, ld_q;
  logic [XLEN-1:0] alu_q, sd_q;
  logic            misalign_q;
  logic            wb_valid_q, wb_reg_wr_q, wb_mem_load_q;
  logic [4:0]      wb_reg_wnum_q;
  logic [XLEN-1:0] wb_alu_q, wb_dat_q, wb_dout_q;

  logic            ex_mem, ex_aligned, accept;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign ex_mem = ex_valid & (ex_mem_load | ex_mem_store);

  always_comb begin
    ex_aligned = 1'b1;
    st_be      = 4'b1111;
    st_wdata   = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_aluresult[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        ex_aligned = ~ex_aluresult[0];
        st_be      = ex_aluresult[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{ex_store_data[15:0]}};
      end
      default: ex_aligned = (ex_aluresult[1:0] == 2'b00);
    endcase
  end

  assign accept = (state_q == IDLE) && ex_mem && ex_aligned;
  // Reset forces every output low, including this combinational one.
  assign stall  = ~rst & (accept | ((state_q == BUSY) & ~dmem_ack));

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      rw_q          <= 1'b0;
      ld_q          <= 1'b0;
      alu_q         <= '0;
      sd_q          <= '0;
      misalign_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_reg_wr_q   <= 1'b0;
      wb_mem_load_q <= 1'b0;
      wb_reg_wnum_q <= '0;
      wb_alu_q      <= '0;
      wb_dat_q      <= '0;
      wb_dout_q     <= '0;
    end else begin
      // M/WB defaults to a bubble; the branches below override on capture.
      misalign_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_reg_wr_q   <= 1'b0;
      wb_mem_load_q <= 1'b0;
      wb_reg_wnum_q <= '0;
      wb_alu_q      <= '0;
      wb_dat_q      <= '0;
      wb_dout_q     <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= ex_mem_store;
            addr_q  <= {ex_aluresult[XLEN-1:2], 2'b00};
            be_q    <= ex_mem_store ? st_be : 4'b0000;
            wdata_q <= ex_mem_store ? st_wdata : '0;
            f3_q    <= ex_funct3;
            off_q   <= ex_aluresult[1:0];
            rd_q    <= ex_reg_wnum;
            rw_q    <= ex_reg_wr;
            ld_q    <= ex_mem_load;
            alu_q   <= ex_aluresult;
            sd_q    <= ex_store_data;
          end else if (ex_valid) begin
            misalign_q    <= ex_mem;
            wb_valid_q    <= 1'b1;
            wb_reg_wr_q   <= ex_reg_wr & ~ex_mem;
            wb_reg_wnum_q <= ex_reg_wnum;
            wb_alu_q      <= ex_aluresult;
            wb_dout_q     <= ex_mem_store ? ex_store_data : '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            wb_valid_q    <= 1'b1;
            wb_reg_wr_q   <= rw_q;
            wb_mem_load_q <= ld_q;
            wb_reg_wnum_q <= rd_q;
            wb_alu_q      <= alu_q;
            wb_dat_q      <= ld_q ? ld_data : '0;
            wb_dout_q     <= ld_q ? '0 : sd_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign misalign       = misalign_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_wr      = wb_reg_wr_q;
  assign wb_mem_load    = wb_mem_load_q;
  assign wb_reg_wnum    = wb_reg_wnum_q;
  assign wb_aluresult   = wb_alu_q;
  assign wb_mem_dat_i_w = wb_dat_q;
  assign wb_data_out    = wb_dout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic against an arithmetic model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_load, ex_mem_store, ex_reg_wr;
  logic [31:0] ex_aluresult, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_reg_wnum;
  logic        stall, dmem_req, dmem_we, dmem_ack, misalign;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_wr, wb_mem_load;
  logic [4:0]  wb_reg_wnum;
  logic [31:0] wb_aluresult, wb_mem_dat_i_w, wb_data_out;

  int n_vec = 0;
  int n_err = 0;

  // observations collected by mem_op
  int          o_stalls, o_reqs;
  logic        o_stable, o_early, o_req_after, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic [40:0] o_bus0;
  logic        o_wb_valid, o_wb_reg_wr, o_wb_mem_load;
  logic [4:0]  o_wb_wnum;
  logic [31:0] o_wb_alu, o_wb_dat, o_wb_dout;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_aluresult(ex_aluresult),
    .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_mem_load(ex_mem_load),
    .ex_mem_store(ex_mem_store), .ex_reg_wr(ex_reg_wr), .ex_reg_wnum(ex_reg_wnum),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .misalign(misalign), .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_mem_load(wb_mem_load),
    .wb_reg_wnum(wb_reg_wnum), .wb_aluresult(wb_aluresult), .wb_mem_dat_i_w(wb_mem_dat_i_w),
    .wb_data_out(wb_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int unsigned sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_aligned(input logic [31:0] a, input logic [2:0] f3);
    return (a % sz(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] m;
    m = ((32'd1 << sz(f3)) - 32'd1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    if (sz(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] r, input logic [31:0] a, input logic [2:0] f3);
    int unsigned s;
    logic [31:0] mask, v;
    s = sz(f3);
    if (s == 4) return r;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = (r >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic drive_ex(input logic v, input logic [2:0] f3, input logic ld, input logic st,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd, input logic rw);
    ex_valid = v; ex_funct3 = f3; ex_mem_load = ld; ex_mem_store = st;
    ex_aluresult = a; ex_store_data = sd; ex_reg_wnum = rd; ex_reg_wr = rw;
  endtask

  // Runs one aligned memory op with `waits` wait cycles before ack and records what the bus/M-WB did.
  task automatic mem_op(input logic [2:0] f3, input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd_word, input int waits,
                        input logic [4:0] rd, input logic rw);
    @(negedge clk);
    drive_ex(1'b1, f3, ld, st, a, sd, rd, rw);
    dmem_ack = 1'b0;
    #1;
    o_stalls = stall ? 1 : 0;
    o_reqs = 0; o_stable = 1'b1; o_early = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (dmem_req) o_reqs++;
      if (wb_valid || misalign) o_early = 1'b1;
      if (k == 0) begin
        o_bus0 = {dmem_we, dmem_addr, dmem_be, dmem_req};
        o_we = dmem_we; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
      end else if ({dmem_we, dmem_addr, dmem_be, dmem_req} !== o_bus0 || dmem_wdata !== o_wdata) begin
        o_stable = 1'b0;
      end
      if (k == waits) begin
        dmem_ack = 1'b1;
        dmem_rdata = rd_word;
      end
      #1;
      if (stall) o_stalls++;
    end
    @(negedge clk);
    o_wb_valid = wb_valid; o_wb_reg_wr = wb_reg_wr; o_wb_mem_load = wb_mem_load;
    o_wb_wnum = wb_reg_wnum; o_wb_alu = wb_aluresult; o_wb_dat = wb_mem_dat_i_w; o_wb_dout = wb_data_out;
    o_req_after = dmem_req;
    ex_valid = 1'b0; dmem_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive_ex(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    n_vec++;
    if ({stall, dmem_req, dmem_we, misalign, dmem_be} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000000", {stall, dmem_req, dmem_we, misalign, dmem_be});
    end
    n_vec++;
    if ({dmem_addr, dmem_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_bus: got %h want 0", {dmem_addr, dmem_wdata});
    end
    n_vec++;
    if ({wb_valid, wb_reg_wr, wb_mem_load, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, wb_data_out} !== 104'h0) begin
      n_err++; $display("FAIL reset_wb: got %h want 0",
                        {wb_valid, wb_reg_wr, wb_mem_load, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, wb_data_out});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, dmem_req, stall} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 000", {wb_valid, dmem_req, stall});
    end
  endtask

  task automatic test_alu;
    @(negedge clk);
    drive_ex(1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd5, 1'b1);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_reg_wr, wb_mem_load, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, wb_data_out, stall}
        !== {1'b1, 1'b1, 1'b0, 5'd5, 32'h10, 32'h0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL alu_wb: got v=%b rw=%b ml=%b rd=%0d alu=%h dat=%h dout=%h st=%b want 1 1 0 5 10 0 0 0",
                        wb_valid, wb_reg_wr, wb_mem_load, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, wb_data_out, stall);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [2];
    logic [31:0] want [2];
    f3s[0] = 3'b000; want[0] = 32'hFFFF_FF80;
    f3s[1] = 3'b100; want[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      mem_op(f3s[i], 1'b1, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 5'd7, 1'b1);
      n_vec++;
      if ({o_addr, o_be, o_we, o_stalls[3:0], o_reqs[3:0]} !== {32'h100, 4'b0000, 1'b0, 4'd1, 4'd1}) begin
        n_err++; $display("FAIL load%0d_bus: got addr=%h be=%b we=%b stalls=%0d reqs=%0d want 100 0000 0 1 1",
                          i, o_addr, o_be, o_we, o_stalls, o_reqs);
      end
      n_vec++;
      if ({o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_wnum, o_wb_alu, o_wb_dat, o_req_after}
          !== {1'b1, 1'b1, 1'b1, 5'd7, 32'h103, want[i], 1'b0}) begin
        n_err++; $display("FAIL load%0d_wb: got v=%b rw=%b ml=%b rd=%0d alu=%h dat=%h req=%b want dat=%h",
                          i, o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_wnum, o_wb_alu, o_wb_dat, o_req_after, want[i]);
      end
    end
  endtask

  task automatic test_store_wait;
    mem_op(3'b001, 1'b0, 1'b1, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 5'd0, 1'b0);
    n_vec++;
    if ({o_addr, o_be, o_we, o_wdata} !== {32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD}) begin
      n_err++; $display("FAIL sh_bus: got addr=%h be=%b we=%b wdata=%h want 200 1100 1 abcdabcd", o_addr, o_be, o_we, o_wdata);
    end
    n_vec++;
    if ({o_reqs[3:0], o_stalls[3:0], o_stable, o_early} !== {4'd4, 4'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sh_hold: got reqs=%0d stalls=%0d stable=%b early=%b want 4 4 1 0", o_reqs, o_stalls, o_stable, o_early);
    end
    n_vec++;
    if ({o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_dout, o_wb_dat, o_req_after}
        !== {1'b1, 1'b0, 1'b0, 32'h1234_ABCD, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL sh_wb: got v=%b rw=%b ml=%b dout=%h dat=%h req=%b want 1 0 0 1234abcd 0 0",
                        o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_dout, o_wb_dat, o_req_after);
    end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive_ex(1'b1, 3'b010, 1'b1, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b want 0", stall); end
    @(negedge clk);
    n_vec++;
    if ({misalign, dmem_req, wb_valid, wb_reg_wr, wb_mem_load, wb_aluresult} !== {5'b10100, 32'h101}) begin
      n_err++; $display("FAIL mis_pulse: got mis=%b req=%b v=%b rw=%b ml=%b alu=%h want 1 0 1 0 0 101",
                        misalign, dmem_req, wb_valid, wb_reg_wr, wb_mem_load, wb_aluresult);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({misalign, dmem_req} !== 2'b00) begin
      n_err++; $display("FAIL mis_end: got mis=%b req=%b want 0 0", misalign, dmem_req);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_ex(1'b1, 3'b010, 1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0);
    dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dmem_req, stall} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_busy: got req=%b stall=%b want 1 1", dmem_req, stall);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({dmem_req, stall, dmem_be} !== 6'b0) begin
      n_err++; $display("FAIL rstmid_drop: got req=%b stall=%b be=%b want 0 0 0000", dmem_req, stall, dmem_be);
    end
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, dmem_req, stall} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_stray_ack: got v=%b req=%b stall=%b want 0 0 0", wb_valid, dmem_req, stall);
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_nowb: got %b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r0, r1;
    r0 = $urandom; r1 = $urandom;
    @(negedge clk);
    drive_ex(1'b1, 3'b010, 1'b1, 1'b0, 32'h0, 32'h0, 5'd10, 1'b1);
    dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL b2b_req0: got req=%b addr=%h want 1 0", dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = r0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_reg_wnum, wb_mem_dat_i_w} !== {1'b1, 5'd10, r0}) begin
      n_err++; $display("FAIL b2b_wb0: got v=%b rd=%0d dat=%h want 1 10 %h", wb_valid, wb_reg_wnum, wb_mem_dat_i_w, r0);
    end
    drive_ex(1'b1, 3'b010, 1'b1, 1'b0, 32'h4, 32'h0, 5'd11, 1'b1);
    dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, dmem_req, dmem_addr} !== {1'b0, 1'b1, 32'h4}) begin
      n_err++; $display("FAIL b2b_req1: got v=%b req=%b addr=%h want 0 1 4", wb_valid, dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = r1;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_reg_wnum, wb_mem_dat_i_w} !== {1'b1, 5'd11, r1}) begin
      n_err++; $display("FAIL b2b_wb1: got v=%b rd=%0d dat=%h want 1 11 %h", wb_valid, wb_reg_wnum, wb_mem_dat_i_w, r1);
    end
    ex_valid = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] a, sd, rw_word;
    logic [4:0]  rd;
    logic        ld, st, rw;
    int          kind, waits;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2);
      f3 = st ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
      a = $urandom; sd = $urandom; rw_word = $urandom; rd = 5'($urandom);
      rw = st ? 1'b0 : 1'b1;
      waits = $urandom_range(0, 3);
      if (kind == 0) begin
        @(negedge clk);
        drive_ex(1'b1, f3, 1'b0, 1'b0, a, sd, rd, rw);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL rnd%0d_alu_stall: got %b want 0", it, stall); end
        @(negedge clk);
        n_vec++;
        if ({wb_valid, wb_reg_wr, wb_mem_load, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, wb_data_out}
            !== {3'b110, rd, a, 32'h0, 32'h0}) begin
          n_err++; $display("FAIL rnd%0d_alu_wb: got v=%b rw=%b rd=%0d alu=%h dat=%h want rd=%0d alu=%h",
                            it, wb_valid, wb_reg_wr, wb_reg_wnum, wb_aluresult, wb_mem_dat_i_w, rd, a);
        end
        ex_valid = 1'b0;
      end else if (!ref_aligned(a, f3)) begin
        @(negedge clk);
        drive_ex(1'b1, f3, ld, st, a, sd, rd, rw);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL rnd%0d_mis_stall: got %b want 0", it, stall); end
        @(negedge clk);
        n_vec++;
        if ({misalign, dmem_req, wb_valid, wb_reg_wr, wb_mem_load} !== 5'b10100) begin
          n_err++; $display("FAIL rnd%0d_mis: got mis=%b req=%b v=%b rw=%b ml=%b want 1 0 1 0 0",
                            it, misalign, dmem_req, wb_valid, wb_reg_wr, wb_mem_load);
        end
        ex_valid = 1'b0;
      end else begin
        mem_op(f3, ld, st, a, sd, rw_word, waits, rd, rw);
        n_vec++;
        if ({o_addr, o_we, o_be} !== {a & 32'hFFFF_FFFC, st, st ? ref_be(a, f3) : 4'b0000}) begin
          n_err++; $display("FAIL rnd%0d_bus: got addr=%h we=%b be=%b want %h %b %b",
                            it, o_addr, o_we, o_be, a & 32'hFFFF_FFFC, st, st ? ref_be(a, f3) : 4'b0000);
        end
        if (st) begin
          n_vec++;
          if (o_wdata !== ref_wdata(sd, f3)) begin
            n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o_wdata, ref_wdata(sd, f3));
          end
        end
        n_vec++;
        if (o_reqs != waits + 1 || o_stalls != waits + 1 || !o_stable || o_early || o_req_after) begin
          n_err++; $display("FAIL rnd%0d_hs: got reqs=%0d stalls=%0d stable=%b early=%b req_after=%b want %0d %0d 1 0 0",
                            it, o_reqs, o_stalls, o_stable, o_early, o_req_after, waits + 1, waits + 1);
        end
        n_vec++;
        if ({o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_wnum, o_wb_alu, o_wb_dat, o_wb_dout}
            !== {1'b1, rw, ld, rd, a, ld ? ref_load(rw_word, a, f3) : 32'h0, st ? sd : 32'h0}) begin
          n_err++; $display("FAIL rnd%0d_wb: got v=%b rw=%b ml=%b rd=%0d alu=%h dat=%h dout=%h want dat=%h dout=%h",
                            it, o_wb_valid, o_wb_reg_wr, o_wb_mem_load, o_wb_wnum, o_wb_alu, o_wb_dat, o_wb_dout,
                            ld ? ref_load(rw_word, a, f3) : 32'h0, st ? sd : 32'h0);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_store_wait;
    test_misalign;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
